// File: rtl/fft_out_reorder_buf.sv
// Ping-pong reorder buffer: accepts bit-reversed FFT output frames and
// replays each completed frame in natural frequency order.
module fft_out_reorder_buf #(
  parameter int unsigned IDX_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic                         din_sof,
  input  logic signed [DATA_WIDTH-1:0] din_re,
  input  logic signed [DATA_WIDTH-1:0] din_im,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DATA_WIDTH-1:0] dout_re,
  output logic signed [DATA_WIDTH-1:0] dout_im,
  output logic [IDX_WIDTH-1:0]         dout_idx,
  output logic                         dout_last,
  output logic                         sof_err
);

  localparam int unsigned MEM_W  = 2 * DATA_WIDTH;
  localparam int unsigned ADDR_W = IDX_WIDTH + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  function automatic logic [IDX_WIDTH-1:0] bitrev(input logic [IDX_WIDTH-1:0] a);
    logic [IDX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(IDX_WIDTH); i++) r[i] = a[int'(IDX_WIDTH) - 1 - i];
    return r;
  endfunction

  logic [MEM_W-1:0]     mem [DEPTH];
  logic [IDX_WIDTH-1:0] wr_cnt;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [1:0]           full;
  logic                 iss_bank;
  logic [IDX_WIDTH-1:0] iss_cnt;
  logic                 s1_v;
  logic [IDX_WIDTH-1:0] s1_idx;
  logic [MEM_W-1:0]     s1_data;

  logic                 din_hs;
  logic                 sof_restart;
  logic                 wr_done;
  logic [IDX_WIDTH-1:0] wr_k;
  logic                 out_adv;
  logic                 issue;
  logic                 rd_release;
  logic [1:0]           full_n;

  // Handshake decode and next-state of the bank full flags
  always_comb begin
    din_hs      = din_valid && din_ready;
    sof_restart = din_hs && din_sof && (wr_cnt != '0);
    wr_k        = sof_restart ? '0 : wr_cnt;
    wr_done     = din_hs && !sof_restart && (wr_cnt == LAST_IDX);
    out_adv     = !dout_valid || dout_ready;
    issue       = full[iss_bank] && (!s1_v || out_adv);
    rd_release  = dout_valid && dout_ready && dout_last;
    full_n      = full;
    if (wr_done)    full_n[wr_bank] = 1'b1;
    if (rd_release) full_n[rd_bank] = 1'b0;
  end

  // Sample storage and read stage; contents need no reset
  always_ff @(posedge clk) begin
    if (din_hs) mem[{wr_bank, bitrev(wr_k)}] <= {din_re, din_im};
    if (issue)  s1_data <= mem[{iss_bank, iss_cnt}];
  end

  // Write side: frame counter, bank pointer, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      din_ready <= 1'b1;
      sof_err   <= 1'b0;
    end else begin
      full      <= full_n;
      din_ready <= !full_n[wr_bank ^ wr_done];
      if (din_hs) wr_cnt <= wr_k + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
      if (sof_restart) sof_err <= 1'b1;
      if (rd_release) rd_bank <= ~rd_bank;
    end
  end

  // Read side: address issue, one-deep read stage, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_bank   <= 1'b0;
      iss_cnt    <= '0;
      s1_v       <= 1'b0;
      s1_idx     <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_idx   <= '0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      if (issue) begin
        iss_cnt <= iss_cnt + 1'b1;
        if (iss_cnt == LAST_IDX) iss_bank <= ~iss_bank;
        s1_v   <= 1'b1;
        s1_idx <= iss_cnt;
      end else if (out_adv) begin
        s1_v <= 1'b0;
      end
      if (out_adv) begin
        dout_valid <= s1_v;
        dout_last  <= s1_v && (s1_idx == LAST_IDX);
        if (s1_v) begin
          dout_idx <= s1_idx;
          dout_re  <= s1_data[MEM_W-1:DATA_WIDTH];
          dout_im  <= s1_data[DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder_buf.sv
// Bench for fft_out_reorder_buf: frame-level reference model (bit-reversed
// frame in, natural-order frame out) with directed and randomized traffic.
module tb_fft_out_reorder_buf;

  localparam int unsigned IW = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 1 << IW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 din_valid, din_ready, din_sof;
  logic signed [DW-1:0] din_re, din_im;
  logic                 dout_valid, dout_ready, dout_last, sof_err;
  logic signed [DW-1:0] dout_re, dout_im;
  logic [IW-1:0]        dout_idx;

  fft_out_reorder_buf #(.IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready), .din_sof(din_sof),
    .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_re(dout_re), .dout_im(dout_im),
    .dout_idx(dout_idx), .dout_last(dout_last), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } smp_t;

  smp_t                 exp_q[$];
  smp_t                 e_mon, tmp_push;
  logic signed [DW-1:0] cur_re[N];
  logic signed [DW-1:0] cur_im[N];
  int                   mcnt, checks, errors, cyc, in_hs_cyc;
  int                   out_n, out_c0, out_c1023, rdy_mode;
  logic                 prev_stall, p_last, coincide;
  logic [IW-1:0]        p_idx;
  logic signed [DW-1:0] p_re, p_im;

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < int'(IW); i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready pattern: 0 low, 1 high, otherwise 50% random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and output scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (din_valid && din_ready) begin
        in_hs_cyc = cyc;
        if (din_sof && mcnt != 0) mcnt = 0;
        cur_re[mcnt] = din_re;
        cur_im[mcnt] = din_im;
        if (mcnt == int'(N) - 1) begin
          if (dout_valid && dout_ready && dout_last) coincide = 1'b1;
          for (int j = 0; j < int'(N); j++) begin
            tmp_push.idx = IW'(j);
            tmp_push.re  = cur_re[brev(j)];
            tmp_push.im  = cur_im[brev(j)];
            exp_q.push_back(tmp_push);
          end
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      if (prev_stall) begin
        chk("hold_idx", dout_idx, p_idx);
        chk("hold_re", dout_re, p_re);
        chk("hold_im", dout_im, p_im);
        chk("hold_last", dout_last, p_last);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", dout_valid, 1'b0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("out_idx", dout_idx, e_mon.idx);
          chk("out_re", dout_re, e_mon.re);
          chk("out_im", dout_im, e_mon.im);
          chk("out_last", dout_last, e_mon.idx == IW'(N - 1));
        end
        if (out_n == 0)    out_c0 = cyc;
        if (out_n == 1023) out_c1023 = cyc;
        out_n++;
      end
      prev_stall = dout_valid && !dout_ready;
      p_idx = dout_idx; p_re = dout_re; p_im = dout_im; p_last = dout_last;
    end
  end

  task automatic send(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                      input logic sof);
    int   n = 0;
    logic hs = 1'b0;
    din_valid = 1'b1; din_re = re; din_im = im; din_sof = sof;
    do begin
      @(negedge clk);
      hs = din_ready && rst_n;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 3000);
    if (!hs) chk("send_timeout", hs, 1'b1);
  endtask

  task automatic send_frame(input int pat, input int len, input logic first_sof);
    logic signed [DW-1:0] re, im;
    for (int k = 0; k < len; k++) begin
      if (pat == 0) begin
        re = DW'(brev(k));
        im = -re;
      end else begin
        re = DW'($urandom);
        im = DW'($urandom);
      end
      send(re, im, first_sof && (k == 0));
    end
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || dout_valid) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n, c_start;
    logic found;
    rst_n = 1'b0; din_valid = 1'b0; din_sof = 1'b0; din_re = '0; din_im = '0;
    dout_ready = 1'b0; rdy_mode = 0; mcnt = 0; coincide = 1'b0; prev_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_ready", din_ready, 1'b1);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_sof_err", sof_err, 1'b0);
    chk("rst_dout_idx", dout_idx, 0);
    chk("rst_dout_last", dout_last, 1'b0);
    chk("rst_dout_re", dout_re, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, bit-reversed ramp, ready high, latency from last input
    rdy_mode = 1;
    idle(2);
    send_frame(0, N, 1'b1);
    din_valid = 1'b0;
    n = 0;
    while (!dout_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_out_latency", cyc - in_hs_cyc, 3);
    wait_drain();
    chk("sof_err_clean", sof_err, 1'b0);

    // Three back-to-back frames against a stalled sink
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_frame(1, N, 1'b1);
    send_frame(1, N, 1'b1);
    @(negedge clk);
    chk("din_ready_both_full", din_ready, 1'b0);
    out_n = 0;
    fork
      send_frame(1, N, 1'b1);
      begin
        repeat (5) @(negedge clk);
        chk("din_ready_held", din_ready, 1'b0);
        chk("dout_valid_held", dout_valid, 1'b1);
        rdy_mode = 1;
      end
    join
    idle(1);
    wait_drain();
    chk("no_gap_two_banks", out_c1023 - out_c0, 1023);
    chk("out_count_3frames", out_n, 3 * int'(N));

    // Random backpressure
    rdy_mode = 2;
    send_frame(1, N, 1'b1);
    send_frame(1, N, 1'b1);
    idle(1);
    wait_drain();

    // Frame completion coinciding with dout_last handshake
    rdy_mode = 1;
    idle(2);
    coincide = 1'b0;
    send_frame(1, N, 1'b1);
    idle(2);
    c_start = cyc;
    send_frame(1, N, 1'b1);
    send_frame(1, N, 1'b1);
    chk("din_ready_high_span", cyc - c_start, 2 * int'(N));
    idle(1);
    wait_drain();
    chk("same_edge_seen", coincide, 1'b1);

    // Misplaced sof at wr_cnt=100
    chk("sof_err_before", sof_err, 1'b0);
    send_frame(1, 100, 1'b1);
    send_frame(1, N, 1'b1);
    idle(1);
    @(negedge clk);
    chk("sof_err_set", sof_err, 1'b1);
    wait_drain();

    // Reset pulse in the middle of output
    send_frame(1, N, 1'b1);
    idle(1);
    n = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      @(negedge clk);
      found = dout_valid && (dout_idx == IW'(37));
      n++;
    end
    chk("idx37_reached", found, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mcnt = 0;
    #1;
    chk("rst_mid_valid", dout_valid, 1'b0);
    chk("rst_mid_idx", dout_idx, 0);
    chk("rst_mid_sof_err", sof_err, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_din_ready", din_ready, 1'b1);
    send_frame(0, N, 1'b1);
    idle(1);
    wait_drain();
    chk("post_rst_sof_err", sof_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
